// File: rtl/dmem_responder.sv
// Data-memory responder with a fixed access latency: it stalls the MEM stage while an
// access is in flight, then pulses rdy in the completion cycle.
module dmem_responder #(
   parameter int ADDR_W = 10,
   parameter int LAT    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic        re,
   input  logic        we,
   input  logic [15:0] wrt_data,
   output logic [15:0] rd_data,
   output logic        stall,
   output logic        rdy,
   output logic        err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
   localparam int         DEPTH    = 1 << ADDR_W;

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              live;
   logic [ADDR_W-1:0] acc_addr;
   logic [15:0]       acc_data;
   logic              acc_we;
   logic [15:0]       mem [0:DEPTH-1];

   logic              can_accept;
   logic              legal;
   logic              illegal;
   logic              accept;
   logic              finish_wait;
   logic              do_access;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              mem_we;

   // live drops asynchronously with rst, so nothing is accepted or written while reset is held
   always_ff @(posedge clk or posedge rst) begin
      if (rst) live <= 1'b0;
      else     live <= 1'b1;
   end

   always_comb begin
      can_accept  = (state == S_IDLE) || (state == S_DONE);
      legal       = re ^ we;
      illegal     = re & we;
      accept      = live & can_accept & legal;
      finish_wait = (state == S_WAIT) && (cnt == 4'd0);
   end

   // With zero latency the access uses the live request; otherwise the latched copy.
   always_comb begin
      if (LAT == 0) begin
         do_access = accept;
         mem_addr  = addr[ADDR_W-1:0];
         mem_wdata = wrt_data;
         mem_we    = we;
      end else begin
         do_access = finish_wait;
         mem_addr  = acc_addr;
         mem_wdata = acc_data;
         mem_we    = acc_we;
      end
   end

   always_comb begin
      stall = 1'b0;
      if (state == S_WAIT)
         stall = (cnt != 4'd0);
      else if (LAT != 0)
         stall = accept;
   end

   assign rdy = (state == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         rd_data <= 16'h0000;
         err     <= 1'b0;
      end else begin
         err <= live & can_accept & illegal;
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  if (LAT == 0) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (cnt != 4'd0) cnt   <= cnt - 4'd1;
               else             state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
         if (do_access && !mem_we)
            rd_data <= mem[mem_addr];
      end
   end

   // Request capture; these only matter while the FSM is in WAIT, so no reset is needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         acc_addr <= addr[ADDR_W-1:0];
         acc_data <= wrt_data;
         acc_we   <= we;
      end
   end

   always_ff @(posedge clk) begin
      if (do_access && mem_we)
         mem[mem_addr] <= mem_wdata;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LAT=2, 0, 3) driven from a vector table
// with a scoreboard of expected rd_data, plus hand-written corner sequences.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] addr     [3];
   logic [15:0] wrt_data [3];
   logic [15:0] rd_data  [3];
   logic        re       [3];
   logic        we       [3];
   logic        stall    [3];
   logic        rdy      [3];
   logic        err      [3];

   int lat_v [3];
   int n_chk  = 0;
   int n_pass = 0;

   logic [15:0] sb [$];
   logic [15:0] last_rd [3];

   typedef struct {
      int          d;
      bit          w;
      logic [15:0] a;
      logic [15:0] wd;
      logic [15:0] rexp;
   } vec_t;

   vec_t tbl [12];

   dmem_responder #(.ADDR_W(10), .LAT(2)) u_lat2 (
      .clk(clk), .rst(rst), .addr(addr[0]), .re(re[0]), .we(we[0]), .wrt_data(wrt_data[0]),
      .rd_data(rd_data[0]), .stall(stall[0]), .rdy(rdy[0]), .err(err[0]));
   dmem_responder #(.ADDR_W(10), .LAT(0)) u_lat0 (
      .clk(clk), .rst(rst), .addr(addr[1]), .re(re[1]), .we(we[1]), .wrt_data(wrt_data[1]),
      .rd_data(rd_data[1]), .stall(stall[1]), .rdy(rdy[1]), .err(err[1]));
   dmem_responder #(.ADDR_W(10), .LAT(3)) u_lat3 (
      .clk(clk), .rst(rst), .addr(addr[2]), .re(re[2]), .we(we[2]), .wrt_data(wrt_data[2]),
      .rd_data(rd_data[2]), .stall(stall[2]), .rdy(rdy[2]), .err(err[2]));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   // One full access: drive, check stall/rdy every cycle, pop the scoreboard on rdy.
   task automatic txn(input int d, input bit w, input logic [15:0] a, input logic [15:0] wd,
                      input logic [15:0] rexp, input string tag);
      @(posedge clk); #1;
      addr[d] = a; wrt_data[d] = wd; we[d] = w; re[d] = !w;
      if (w) sb.push_back(last_rd[d]);
      else begin
         sb.push_back(rexp);
         last_rd[d] = rexp;
      end
      for (int c = 0; c <= lat_v[d] + 1; c++) begin
         @(negedge clk);
         check({tag, " stall"}, 16'(stall[d]), 16'(c < lat_v[d]));
         check({tag, " rdy"},   16'(rdy[d]),   16'(c == lat_v[d] + 1));
         if (rdy[d]) begin
            if (sb.size() == 0) check({tag, " scoreboard empty"}, 16'd0, 16'd1);
            else                check({tag, " rd_data"}, rd_data[d], sb.pop_front());
         end
         @(posedge clk); #1;
         if (c == lat_v[d]) begin
            re[d] = 1'b0;
            we[d] = 1'b0;
         end
      end
   endtask

   initial begin
      lat_v[0] = 2; lat_v[1] = 0; lat_v[2] = 3;
      for (int i = 0; i < 3; i++) begin
         addr[i] = '0; wrt_data[i] = '0; re[i] = 1'b0; we[i] = 1'b0; last_rd[i] = 16'h0000;
      end

      tbl[0]  = '{0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
      tbl[1]  = '{0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
      tbl[2]  = '{0, 1'b1, 16'h0020, 16'h5555, 16'h0000};
      tbl[3]  = '{0, 1'b1, 16'h0403, 16'h00AA, 16'h0000};
      tbl[4]  = '{0, 1'b0, 16'h0003, 16'h0000, 16'h00AA};
      tbl[5]  = '{0, 1'b1, 16'h0040, 16'h7777, 16'h0000};
      tbl[6]  = '{0, 1'b1, 16'h0041, 16'h8888, 16'h0000};
      tbl[7]  = '{1, 1'b1, 16'h0100, 16'hCAFE, 16'h0000};
      tbl[8]  = '{1, 1'b0, 16'h0100, 16'h0000, 16'hCAFE};
      tbl[9]  = '{2, 1'b1, 16'h0030, 16'h1111, 16'h0000};
      tbl[10] = '{2, 1'b0, 16'h0030, 16'h0000, 16'h1111};
      tbl[11] = '{0, 1'b0, 16'h0041, 16'h0000, 16'h8888};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("reset stall",   16'(stall[i]), 16'd0);
         check("reset rdy",     16'(rdy[i]),   16'd0);
         check("reset err",     16'(err[i]),   16'd0);
         check("reset rd_data", rd_data[i],    16'h0000);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 12; i++)
         txn(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].rexp, $sformatf("vec%0d", i));

      // LAT=0 back-to-back write then read
      @(posedge clk); #1;
      we[1] = 1'b1; addr[1] = 16'h0005; wrt_data[1] = 16'h1234;
      @(negedge clk);
      check("b2b c0 stall", 16'(stall[1]), 16'd0);
      check("b2b c0 rdy",   16'(rdy[1]),   16'd0);
      @(posedge clk); #1;
      we[1] = 1'b0; re[1] = 1'b1;
      @(negedge clk);
      check("b2b c1 stall", 16'(stall[1]), 16'd0);
      check("b2b c1 rdy",   16'(rdy[1]),   16'd1);
      @(posedge clk); #1;
      re[1] = 1'b0;
      @(negedge clk);
      check("b2b c2 stall",   16'(stall[1]), 16'd0);
      check("b2b c2 rdy",     16'(rdy[1]),   16'd1);
      check("b2b c2 rd_data", rd_data[1],    16'h1234);
      last_rd[1] = 16'h1234;
      @(negedge clk);
      check("b2b c3 rdy", 16'(rdy[1]), 16'd0);

      // Illegal request on LAT=2 instance
      @(posedge clk); #1;
      re[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0020; wrt_data[0] = 16'hFFFF;
      @(negedge clk);
      check("illegal c0 stall", 16'(stall[0]), 16'd0);
      check("illegal c0 err",   16'(err[0]),   16'd0);
      @(posedge clk); #1;
      re[0] = 1'b0; we[0] = 1'b0;
      @(negedge clk);
      check("illegal c1 err",   16'(err[0]),   16'd1);
      check("illegal c1 rdy",   16'(rdy[0]),   16'd0);
      check("illegal c1 stall", 16'(stall[0]), 16'd0);
      @(negedge clk);
      check("illegal c2 err", 16'(err[0]), 16'd0);
      txn(0, 1'b0, 16'h0020, 16'h0000, 16'h5555, "illegal readback");

      // Address change after acceptance is ignored
      @(posedge clk); #1;
      re[0] = 1'b1; addr[0] = 16'h0040;
      @(posedge clk); #1;
      addr[0] = 16'h0041;
      @(posedge clk); #1;
      @(posedge clk); #1;
      re[0] = 1'b0;
      @(negedge clk);
      check("latched rdy",     16'(rdy[0]), 16'd1);
      check("latched rd_data", rd_data[0],  16'h7777);
      last_rd[0] = 16'h7777;

      // Reset in the middle of a LAT=3 write
      @(posedge clk); #1;
      we[2] = 1'b1; addr[2] = 16'h0030; wrt_data[2] = 16'hDEAD;
      @(negedge clk);
      check("rst c0 stall", 16'(stall[2]), 16'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst stall",      16'(stall[2]), 16'd0);
      check("rst rdy",        16'(rdy[2]),   16'd0);
      check("rst rd_data",    rd_data[2],    16'h0000);
      check("rst rd_data u0", rd_data[0],    16'h0000);
      we[2] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) last_rd[i] = 16'h0000;
      txn(2, 1'b0, 16'h0030, 16'h0000, 16'h1111, "rst readback");

      check("scoreboard drained", 16'(sb.size()), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the CPU's data-memory port: the target of the load/store requests the MEM stage drives with addr, re, we and wrt_data. It holds a word-addressed 16-bit storage array and models configurable access latency. While an access is in flight it asserts stall to freeze the pipeline, then pulses rdy when read data is valid. It replaces the zero-wait data memory so the pipeline's stall path can be exercised.

Parameters:
ADDR_W, 10, number of word-address bits; the array holds 2^ADDR_W 16-bit words.
LAT, 2, wait cycles per access (0..15); 0 means single-cycle, no stall.

Ports:
clk  input  1  global clock, rising edge
rst  input  1  asynchronous reset, active-high
addr  input  16  word address; only addr[ADDR_W-1:0] is used, upper bits are ignored (aliasing)
re  input  1  read request from the MEM stage
we  input  1  write request from the MEM stage
wrt_data  input  16  store data
rd_data  output  16  load data, held until the next read completes
stall  output  1  combinational; pipeline must hold the request stable while this is high
rdy  output  1  one-cycle pulse marking completion of any access (read or write)
err  output  1  one-cycle pulse flagging an illegal request (re and we both high)

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, rd_data=0x0000, rdy=0, stall=0, err=0. Any pending access is dropped and the array is not written. The array contents are NOT reset.
- States:
  - IDLE: no access in flight.
  - WAIT: access latched; a 4-bit down-counter runs.
  - DONE: completion cycle.
- Accept: in IDLE or DONE, a request is accepted when exactly one of re/we is high. At the accepting edge, addr[ADDR_W-1:0], wrt_data and the access type are latched. Input changes after acceptance are ignored.
- Timing, with the request first visible in cycle 0:
  - LAT>0: stall=1 in cycles 0..LAT-1. At edge 0 the state goes WAIT with counter=LAT-1. In WAIT, the counter decrements each edge and stall=(counter!=0), so stall=0 in cycle LAT. The array access happens at the edge ending cycle LAT, then the state goes DONE.
  - LAT=0: stall is never asserted. The access happens at edge 0 and the state goes DONE.
- Cycle LAT+1 (DONE): rdy=1. For a read, rd_data holds the addressed word from this cycle onward; for a write, rd_data is unchanged.
- DONE may accept a new request in the same cycle, which allows back-to-back accesses. If no request is present, DONE returns to IDLE.
- The request in cycle LAT (state WAIT, stall low) is the same instruction and is not re-accepted.
- Illegal request (re=we=1 in IDLE/DONE): no access, no stall; err=1 for one cycle in the following cycle; state goes IDLE.
- Writes store the full 16-bit word. A read after a write to the same address returns the new data; accesses are serialized, so there is no read/write collision.
- No request (re=we=0): stall=0 and state settles to IDLE.

Test Plan:
1. LAT=2: write 0xBEEF to 0x0010 in cycle 0 -> stall=1 in cycles 0-1, 0 in cycle 2, rdy=1 in cycle 3; then read 0x0010 -> rdy=1 and rd_data=0xBEEF three cycles after the read appears.
2. LAT=0: write 0x1234 to 0x0005 in cycle 0, read 0x0005 in cycle 1 -> stall never 1, rdy in cycles 1 and 2, rd_data=0x1234 in cycle 2.
3. ADDR_W=10: write 0x00AA to 0x0403, read 0x0003 -> rd_data=0x00AA (aliasing).
4. re=we=1 at addr 0x0020 previously holding 0x5555 -> err=1 next cycle, stall=0, rdy=0; a later read of 0x0020 returns 0x5555.
5. LAT=3: write 0xDEAD to 0x0030 (old value 0x1111), assert rst in cycle 1 -> stall, rdy and rd_data are 0 immediately; after release, a read of 0x0030 returns 0x1111.
6. LAT=2: read 0x0040 (holding 0x7777), with addr changed to 0x0041 in cycle 1 -> rd_data=0x7777 (latched address used).
